// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver (8E1 when UART_RX_PARITY_EN is defined) feeding a 2**FIFO_AW-entry byte FIFO.
// Latency: a byte is pushed at its stop-bit sample; dout/dout_valid present it the following cycle.
// Backpressure: the consumer holds dout_ready low to stall; a byte arriving while full is dropped and flags overrun.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_AW      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    input  logic       err_clr,
    output logic       overrun,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       par_err,
`endif
    output logic       busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t            state;
    logic              rx_m, rx_s;
    logic [CW-1:0]     cnt;
    logic [2:0]        bits;
    logic [7:0]        shreg;
    logic [7:0]        mem [DEPTH];
    logic [FIFO_AW:0]  wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic              bit_end, push, pop, push_ok, full, stop_bad;

    assign bit_end    = (cnt == BIT_LAST);
    assign push       = (state == STOP) && bit_end && rx_s;
    assign stop_bad   = (state == STOP) && bit_end && !rx_s;
    assign full       = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                        (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign dout_valid = (wr_ptr != rd_ptr);
    assign pop        = dout_valid & dout_ready;
    assign push_ok    = push & (~full | pop);
    assign wr_nxt     = wr_ptr + (FIFO_AW+1)'(push_ok);
    assign rd_nxt     = rd_ptr + (FIFO_AW+1)'(pop);
    assign busy       = (state != IDLE);

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            bits  <= '0;
            shreg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt  <= '0;
                        bits <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[7:1]};
                        bits  <= bits + 1'b1;
`ifdef UART_RX_PARITY_EN
                        if (bits == 3'd7) state <= PARITY;
`else
                        if (bits == 3'd7) state <= STOP;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= rx_s ? IDLE : BREAK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    cnt <= '0;
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[FIFO_AW-1:0]] <= shreg;
    end

    // dout is registered to the post-edge head; a byte landing in an empty slot bypasses mem.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout   <= '0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            if (wr_nxt != rd_nxt) begin
                if (push_ok && (rd_nxt[FIFO_AW-1:0] == wr_ptr[FIFO_AW-1:0]))
                    dout <= shreg;
                else
                    dout <= mem[rd_nxt[FIFO_AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (push & full & ~pop) overrun <= 1'b1;
            else if (err_clr)       overrun <= 1'b0;
            if (stop_bad)           frame_err <= 1'b1;
            else if (err_clr)       frame_err <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err <= 1'b0;
        end else if ((state == PARITY) && bit_end && (rx_s != ^shreg)) begin
            par_err <= 1'b1;
        end else if (err_clr) begin
            par_err <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames driven bit by bit, received bytes checked against a queue.
module tb_uart_rx_fifo;

    localparam int CPB = 8;
    localparam int AW  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       dout_ready = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] dout;
    logic       dout_valid, overrun, frame_err, busy;
`ifdef UART_RX_PARITY_EN
    logic       par_err;
    logic       par_flip = 1'b0;
`endif

    int         n_cmp = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .err_clr    (err_clr),
        .overrun    (overrun),
        .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
        .par_err    (par_err),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_val, input int stop_len);
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) tick();
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ par_flip;
        repeat (CPB) tick();
`endif
        rx = stop_val;
        repeat (stop_len) tick();
    endtask

    task automatic pop_one();
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (10) tick();
        n_cmp++;
        if (dout !== 8'h00 || dout_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: got dout=%h valid=%b want 00/0", dout, dout_valid);
        end
        n_cmp++;
        if (overrun !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got ovr=%b ferr=%b busy=%b want 0/0/0", overrun, frame_err, busy);
        end
        rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_single();
        int vcnt;
        logic [7:0] exp;
        vcnt = 0;
        dout_ready = 1'b1;
        exp_q.push_back(8'h55);
        fork
            send_byte(8'h55, 1'b1, CPB);
            for (int i = 0; i < 110; i++) begin
                tick();
                if (dout_valid === 1'b1) begin
                    vcnt++;
                    if (vcnt == 1) begin
                        exp = exp_q.pop_front();
                        n_cmp++;
                        if (dout !== exp) begin
                            n_fail++;
                            $display("FAIL single_data: got %h want %h", dout, exp);
                        end
                    end
                end
            end
        join
        dout_ready = 1'b0;
        n_cmp++;
        if (vcnt != 1) begin
            n_fail++;
            $display("FAIL single_valid_cycles: got %0d want 1", vcnt);
        end
        n_cmp++;
        if (overrun !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_flags: got ovr=%b ferr=%b busy=%b want 0/0/0", overrun, frame_err, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [4];
        logic [7:0] exp;
        bytes[0] = 8'hA3; bytes[1] = 8'h00; bytes[2] = 8'hFF; bytes[3] = 8'h7E;
        dout_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(bytes[i]);
            send_byte(bytes[i], 1'b1, CPB);
        end
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_no_overrun: got %b want 0", overrun);
        end
        send_byte(8'h11, 1'b1, CPB);
        n_cmp++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_overrun: got %b want 1", overrun);
        end
        for (int i = 0; i < 4; i++) begin
            exp = exp_q.pop_front();
            n_cmp++;
            if (dout_valid !== 1'b1 || dout !== exp) begin
                n_fail++;
                $display("FAIL fill_pop%0d: got valid=%b dout=%h want 1/%h", i, dout_valid, dout, exp);
            end
            pop_one();
        end
        n_cmp++;
        if (dout_valid !== 1'b0 || dout !== 8'h7E) begin
            n_fail++;
            $display("FAIL fill_drained: got valid=%b dout=%h want 0/7e", dout_valid, dout);
        end
        pop_one();
        n_cmp++;
        if (dout_valid !== 1'b0 || dout !== 8'h7E) begin
            n_fail++;
            $display("FAIL empty_pop: got valid=%b dout=%h want 0/7e", dout_valid, dout);
        end
        clear_errs();
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clear: got %b want 0", overrun);
        end
    endtask

    task automatic test_glitch();
        logic saw_busy;
        saw_busy = 1'b0;
        rx = 1'b0;
        repeat (2) tick();
        rx = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (busy === 1'b1) saw_busy = 1'b1;
        end
        n_cmp++;
        if (saw_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_busy_seen: got %b want 1", saw_busy);
        end
        n_cmp++;
        if (busy !== 1'b0 || dout_valid !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_idle: got busy=%b valid=%b ferr=%b want 0/0/0", busy, dout_valid, frame_err);
        end
    endtask

    task automatic test_break();
        logic [7:0] exp;
        dout_ready = 1'b0;
        send_byte(8'hC4, 1'b0, 20 * CPB);
        n_cmp++;
        if (frame_err !== 1'b1 || dout_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL break_hold: got ferr=%b valid=%b busy=%b want 1/0/1", frame_err, dout_valid, busy);
        end
        rx = 1'b1;
        repeat (4) tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL break_release: got busy=%b want 0", busy);
        end
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1, CPB);
        exp = exp_q.pop_front();
        n_cmp++;
        if (dout_valid !== 1'b1 || dout !== exp || frame_err !== 1'b1) begin
            n_fail++;
            $display("FAIL break_next: got valid=%b dout=%h ferr=%b want 1/%h/1", dout_valid, dout, frame_err, exp);
        end
        pop_one();
        clear_errs();
        n_cmp++;
        if (frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_err_clear: got %b want 0", frame_err);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp;
        dout_ready = 1'b0;
        send_byte(8'h5A, 1'b1, CPB);
        n_cmp++;
        if (dout_valid !== 1'b1 || dout !== 8'h5A) begin
            n_fail++;
            $display("FAIL pre_reset_byte: got valid=%b dout=%h want 1/5a", dout_valid, dout);
        end
        fork
            send_byte(8'h99, 1'b1, CPB);
            begin
                repeat (30) tick();
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL mid_frame_busy: got %b want 1", busy);
                end
                #3 rst = 1'b1;
                #1;
                n_cmp++;
                if (busy !== 1'b0 || dout_valid !== 1'b0 || dout !== 8'h00 || overrun !== 1'b0 || frame_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL async_reset: got busy=%b valid=%b dout=%h ovr=%b ferr=%b want 0/0/00/0/0",
                             busy, dout_valid, dout, overrun, frame_err);
                end
            end
        join
        tick();
        rst = 1'b0;
        repeat (2) tick();
        exp_q.push_back(8'h42);
        send_byte(8'h42, 1'b1, CPB);
        exp = exp_q.pop_front();
        n_cmp++;
        if (dout_valid !== 1'b1 || dout !== exp) begin
            n_fail++;
            $display("FAIL after_reset_byte: got valid=%b dout=%h want 1/%h", dout_valid, dout, exp);
        end
        pop_one();
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        logic [7:0] exp;
        dout_ready = 1'b0;
        par_flip = 1'b1;
        exp_q.push_back(8'h07);
        send_byte(8'h07, 1'b1, CPB);
        par_flip = 1'b0;
        exp = exp_q.pop_front();
        n_cmp++;
        if (par_err !== 1'b1 || dout_valid !== 1'b1 || dout !== exp) begin
            n_fail++;
            $display("FAIL parity_bad: got perr=%b valid=%b dout=%h want 1/1/%h", par_err, dout_valid, dout, exp);
        end
        pop_one();
        clear_errs();
        exp_q.push_back(8'h07);
        send_byte(8'h07, 1'b1, CPB);
        exp = exp_q.pop_front();
        n_cmp++;
        if (par_err !== 1'b0 || dout_valid !== 1'b1 || dout !== exp) begin
            n_fail++;
            $display("FAIL parity_good: got perr=%b valid=%b dout=%h want 0/1/%h", par_err, dout_valid, dout, exp);
        end
        pop_one();
    endtask
`endif

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_break();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
